// File: rtl/lut_pkg.sv
// Shared constants for the programmable 8-entry lookup table.
// The state encodings stay as plain 2-bit constants so that existing code can keep using them.
package lut_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  localparam int unsigned LUT_DEPTH = 8;
  localparam int unsigned ADDR_W    = 3;

  // True when the write pointer is on the last table entry.
  function automatic logic is_last_addr(input logic [ADDR_W-1:0] addr);
    return addr == ADDR_W'(LUT_DEPTH - 1);
  endfunction

endpackage

// File: rtl/lut_8x2_store.sv
// Register array of LUT_DEPTH x WIDTH entries with one write port and a registered read port.
// While ren is low, the read register loads zero instead of array data.
module lut_8x2_store
  import lut_pkg::*;
#(
  parameter int unsigned WIDTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              ren,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [LUT_DEPTH];

  // A write and a read to the same address in one cycle return the previous contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdata <= '0;
    end else begin
      if (we) begin
        mem[waddr] <= wdata;
      end
      rdata <= ren ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/lut_8x2_writer.sv
// Lookup table with 8 entries that is loaded at runtime over a valid/ready port.
// It serves registered lookups on {A,B,C} after a complete load: OUT[1] = F and OUT[0] = G.
module lut_8x2_writer
  import lut_pkg::*;
#(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  output logic             din_ready,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  output logic [WIDTH-1:0] OUT,
  output logic             programmed,
  output logic [3:0]       load_cnt,
  output logic             err
);

  localparam int unsigned IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [IW-1:0]     idle_cnt;
  logic              xfer;
  logic              we;
  logic              timeout_hit;

  assign din_ready   = (state == ST_LOAD);
  assign xfer        = din_valid && din_ready;
  // load_start takes priority over a beat in the same cycle, so that beat is discarded.
  assign we          = xfer && !load_start;
  assign timeout_hit = (TIMEOUT != 0) && !xfer && (idle_cnt == IW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      load_cnt   <= '0;
      idle_cnt   <= '0;
      programmed <= 1'b0;
      err        <= 1'b0;
    end else if (load_start) begin
      state      <= ST_LOAD;
      ptr        <= '0;
      load_cnt   <= '0;
      idle_cnt   <= '0;
      programmed <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (xfer) begin
            ptr      <= ptr + 1'b1;
            load_cnt <= load_cnt + 4'd1;
            idle_cnt <= '0;
            if (is_last_addr(ptr)) begin
              state      <= ST_READY;
              programmed <= 1'b1;
            end
          end else if (timeout_hit) begin
            state    <= ST_IDLE;
            err      <= 1'b1;
            idle_cnt <= '0;
          end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        ST_IDLE, ST_READY: begin
        end
        default: begin
          state      <= ST_IDLE;
          programmed <= 1'b0;
        end
      endcase
    end
  end

  lut_8x2_store #(
    .WIDTH(WIDTH)
  ) u_store (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (ptr),
    .wdata (din),
    .raddr ({A, B, C}),
    .ren   (programmed),
    .rdata (OUT)
  );

endmodule

// File: tb/tb_lut_8x2_writer.sv
// Scoreboard testbench for lut_8x2_writer. A bench-side table model sets the expected lookup results.
module tb_lut_8x2_writer;

  logic       clk = 1'b0;
  logic       reset, load_start, din_valid;
  logic [1:0] din;
  logic       A, B, C;
  logic       din_ready, programmed, err;
  logic [1:0] OUT;
  logic [3:0] load_cnt;

  int checks = 0;
  int errors = 0;

  logic [1:0] m_mem [8];
  logic       m_prog;
  int         m_ptr;
  logic [1:0] pat   [8];
  logic [1:0] exp_q [$];

  lut_8x2_writer #(
    .WIDTH   (2),
    .TIMEOUT (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .A          (A),
    .B          (B),
    .C          (C),
    .OUT        (OUT),
    .programmed (programmed),
    .load_cnt   (load_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pat(input logic [1:0] v);
    for (int i = 0; i < 8; i++) pat[i] = v;
  endtask

  task automatic pulse_start;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_ptr  = 0;
    m_prog = 1'b0;
  endtask

  task automatic load_beats(input int n);
    for (int i = 0; i < n; i++) begin
      din_valid = 1'b1;
      din       = pat[i];
      tick();
      m_mem[m_ptr] = pat[i];
      m_ptr++;
      if (m_ptr == 8) begin
        m_ptr  = 0;
        m_prog = 1'b1;
      end
    end
    din_valid = 1'b0;
  endtask

  // Drive every address for one cycle each, then compare OUT with the scoreboard queue.
  task automatic sweep(input string tag);
    logic [1:0] e;
    for (int a = 0; a < 8; a++) begin
      {A, B, C} = 3'(a);
      exp_q.push_back(m_prog ? m_mem[a] : 2'b00);
      tick();
      e = exp_q.pop_front();
      checks++;
      if (OUT !== e) begin
        errors++;
        $display("FAIL %s_out[%0d]: got %b want %b", tag, a, OUT, e);
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; load_start = 1'b0; din_valid = 1'b0; din = 2'b00; {A, B, C} = 3'b000;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_mem[i] = 2'b00;
    m_prog = 1'b0; m_ptr = 0;
    checks++; if (OUT !== 2'b00) begin errors++; $display("FAIL rst_out: got %b want 00", OUT); end
    checks++; if (programmed !== 1'b0) begin errors++; $display("FAIL rst_programmed: got %b want 0", programmed); end
    checks++; if (load_cnt !== 4'd0) begin errors++; $display("FAIL rst_load_cnt: got %0d want 0", load_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", err); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL rst_din_ready: got %b want 0", din_ready); end
  endtask

  task automatic test_load;
    pat[0] = 2'b11; pat[1] = 2'b11; pat[2] = 2'b10; pat[3] = 2'b00;
    pat[4] = 2'b01; pat[5] = 2'b01; pat[6] = 2'b10; pat[7] = 2'b01;
    {A, B, C} = 3'b000;
    pulse_start();
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL load_din_ready: got %b want 1", din_ready); end
    checks++; if (load_cnt !== 4'd0) begin errors++; $display("FAIL load_cnt_start: got %0d want 0", load_cnt); end
    load_beats(7);
    checks++; if (load_cnt !== 4'd7) begin errors++; $display("FAIL load_cnt_7: got %0d want 7", load_cnt); end
    checks++; if (programmed !== 1'b0) begin errors++; $display("FAIL load_prog_early: got %b want 0", programmed); end
    for (int i = 0; i < 7; i++) pat[i] = pat[7];
    m_ptr = 7;
    pat[0] = 2'b01;
    din_valid = 1'b1; din = 2'b01;
    tick();
    din_valid = 1'b0;
    m_mem[7] = 2'b01; m_ptr = 0; m_prog = 1'b1;
    checks++; if (programmed !== 1'b1) begin errors++; $display("FAIL load_programmed: got %b want 1", programmed); end
    checks++; if (load_cnt !== 4'd8) begin errors++; $display("FAIL load_cnt_8: got %0d want 8", load_cnt); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL load_ready_done: got %b want 0", din_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_err: got %b want 0", err); end
    checks++; if (OUT !== 2'b00) begin errors++; $display("FAIL load_out_latency: got %b want 00", OUT); end
    sweep("load");
  endtask

  task automatic test_ready_ignore;
    {A, B, C} = 3'b000;
    din_valid = 1'b1; din = 2'b00;
    repeat (10) tick();
    din_valid = 1'b0;
    checks++; if (programmed !== 1'b1) begin errors++; $display("FAIL ign_programmed: got %b want 1", programmed); end
    checks++; if (load_cnt !== 4'd8) begin errors++; $display("FAIL ign_load_cnt: got %0d want 8", load_cnt); end
    checks++; if (OUT !== 2'b11) begin errors++; $display("FAIL ign_out000: got %b want 11", OUT); end
    sweep("ign");
  endtask

  task automatic test_reload;
    {A, B, C} = 3'b000;
    pulse_start();
    checks++; if (programmed !== 1'b0) begin errors++; $display("FAIL reload_programmed: got %b want 0", programmed); end
    tick();
    checks++; if (OUT !== 2'b00) begin errors++; $display("FAIL reload_out_forced: got %b want 00", OUT); end
    fill_pat(2'b01);
    load_beats(8);
    checks++; if (programmed !== 1'b1) begin errors++; $display("FAIL reload_prog_done: got %b want 1", programmed); end
    sweep("reload");
  endtask

  task automatic test_timeout;
    pat[0] = 2'b01; pat[1] = 2'b10; pat[2] = 2'b11; pat[3] = 2'b01; pat[4] = 2'b10;
    pulse_start();
    load_beats(5);
    checks++; if (load_cnt !== 4'd5) begin errors++; $display("FAIL to_load_cnt: got %0d want 5", load_cnt); end
    repeat (15) tick();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_err_early: got %b want 0", err); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL to_ready_early: got %b want 1", din_ready); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_err: got %b want 1", err); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL to_din_ready: got %b want 0", din_ready); end
    checks++; if (programmed !== 1'b0) begin errors++; $display("FAIL to_programmed: got %b want 0", programmed); end
    sweep("to");
  endtask

  task automatic test_restart;
    pulse_start();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rs_err_clear: got %b want 0", err); end
    fill_pat(2'b01);
    load_beats(4);
    load_start = 1'b1; din_valid = 1'b1; din = 2'b11;
    tick();
    load_start = 1'b0; din_valid = 1'b0;
    m_ptr = 0;
    checks++; if (load_cnt !== 4'd0) begin errors++; $display("FAIL rs_load_cnt: got %0d want 0", load_cnt); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL rs_din_ready: got %b want 1", din_ready); end
    fill_pat(2'b10);
    load_beats(7);
    load_start = 1'b1; din_valid = 1'b1; din = 2'b11;
    tick();
    load_start = 1'b0; din_valid = 1'b0;
    m_ptr = 0;
    checks++; if (programmed !== 1'b0) begin errors++; $display("FAIL rs_last_prog: got %b want 0", programmed); end
    checks++; if (load_cnt !== 4'd0) begin errors++; $display("FAIL rs_last_cnt: got %0d want 0", load_cnt); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL rs_last_ready: got %b want 1", din_ready); end
    load_beats(8);
    sweep("rs");
  endtask

  task automatic test_reset_midload;
    pulse_start();
    fill_pat(2'b01);
    load_beats(6);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_mem[i] = 2'b00;
    m_prog = 1'b0; m_ptr = 0;
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL mr_din_ready: got %b want 0", din_ready); end
    checks++; if (load_cnt !== 4'd0) begin errors++; $display("FAIL mr_load_cnt: got %0d want 0", load_cnt); end
    checks++; if (programmed !== 1'b0) begin errors++; $display("FAIL mr_programmed: got %b want 0", programmed); end
    pulse_start();
    fill_pat(2'b11);
    load_beats(8);
    sweep("mr");
  endtask

  initial begin
    test_reset();
    test_load();
    test_ready_ignore();
    test_reload();
    test_timeout();
    test_restart();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_8x2_writer.md
Name: lut_8x2_writer

Overview:
- Programmable 8-entry x 2-bit lookup table, the write-side counterpart of the fixed 8x2 ROM LUTs in lista-3.
- Contents are streamed in one entry per beat over a valid/ready load port. Address 0 is loaded first and address 7 last.
- Once all 8 entries are loaded, the table serves combinational-address, registered-data lookups on A, B, C, with the same bit mapping as the ROM blocks: OUT[1] = F, OUT[0] = G.
- Used to re-target F/G truth tables at runtime without resynthesis.

Parameters:
- WIDTH, 2, bits per entry (OUT and din width).
- TIMEOUT, 16, maximum idle cycles between load beats before the load aborts; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_start  input  1  one-cycle pulse; begins (or restarts) a table load.
- din_valid  input  1  load beat valid.
- din  input  WIDTH  entry data for the current write pointer.
- din_ready  output  1  high while in LOAD; a beat transfers when din_valid && din_ready.
- A  input  1  address MSB.
- B  input  1  address bit 1.
- C  input  1  address LSB.
- OUT  output  WIDTH  registered lookup result DATA[{A,B,C}].
- programmed  output  1  table holds a complete, valid load.
- load_cnt  output  4  number of entries written in the current load (0..8).
- err  output  1  sticky; set by a load timeout; cleared by load_start or reset.

Behaviour:
- States: IDLE, LOAD, READY. The state encoding is 2 bits.
- Reset values:
  - state = IDLE
  - all DATA entries = 0
  - OUT = 0, programmed = 0, load_cnt = 0, err = 0
  - din_ready = 0, write pointer = 0, idle counter = 0
- IDLE or READY, load_start = 1:
  - next state LOAD
  - write pointer, load_cnt and idle counter go to 0
  - programmed and err go to 0
  - DATA is not cleared.
- LOAD:
  - din_ready = 1 (decoded from state).
  - On each transfer: DATA[ptr] <= din, ptr++, load_cnt++, idle counter <= 0.
  - Transfer with ptr = 7: next state READY, programmed <= 1, load_cnt = 8, ptr wraps to 0.
  - Cycle with no transfer: idle counter++.
  - Idle counter reaches TIMEOUT (TIMEOUT != 0): next state IDLE, err <= 1, programmed stays 0.
  - Partially written entries are retained but unusable.
- load_start during LOAD restarts the load (ptr = 0, load_cnt = 0). Any beat presented in that same cycle is discarded; load_start has priority over a transfer.
- load_start in the same cycle as the final (8th) beat also restarts; READY is not entered.
- Lookup path:
  - Each cycle, OUT <= programmed ? DATA[{A,B,C}] : 0.
  - Latency is 1 cycle from an address change to OUT.
  - programmed rises the cycle after the 8th beat, so the first valid OUT appears 2 cycles after the 8th beat.
  - In LOAD and IDLE, OUT is forced to 0.
- reset mid-load returns to IDLE and clears DATA; reset has priority over every other input.
- din_valid outside LOAD is ignored; DATA is unchanged.

Decomposition:
- Shared package lut_pkg holds:
  - state localparams: ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_READY = 2'd2
  - LUT_DEPTH = 8
  - ADDR_W = 3
- One natural sub-module: lut_8x2_store, the 8xWIDTH register array.
  - Write port: we, waddr, wdata. Read port: raddr, registered rdata. Synchronous clear on reset.
  - The FSM, pointer and timeout logic stay in lut_8x2_writer.

Test Plan:
1. Reset, then load beats 11, 11, 10, 00, 01, 01, 10, 01 back-to-back; sweep ABC = 000..111 -> OUT sequence 11, 11, 10, 00, 01, 01, 10, 01 (1-cycle latency); programmed = 1; load_cnt = 8; err = 0.
2. Load 5 beats, then hold din_valid = 0 for 16 cycles -> state returns to IDLE, err = 1, programmed = 0, OUT = 00 for every ABC.
3. Load 4 beats, pulse load_start with din_valid = 1 (din = 11) -> that beat is dropped and load_cnt = 0; then load 8 beats of 10 -> OUT = 10 for all addresses.
4. From READY holding the table from test 1, pulse load_start -> OUT = 00 and programmed = 0 on the next cycles; load all 01 -> ABC = 000 gives 01.
5. Assert reset after 6 beats -> next cycle: state IDLE, load_cnt = 0, din_ready = 0; after a fresh load of all 11, every ABC gives OUT = 11.
6. In READY, drive din_valid = 1, din = 00 for 10 cycles without load_start -> DATA unchanged; ABC = 000 still gives 11 (table from test 1).
